// File: rtl/audio_pkg.sv
// Shared constants, handshake bundle and sample conversion
// for the ADC audio frame capture front-end.
package audio_pkg;

    localparam int AUDIO_DATA_W    = 8;
    localparam int AUDIO_FRAME_LEN = 64;

    typedef struct packed {
        logic valid;
        logic ack;
        logic overrun;
    } frame_hs_t;

    // Offset-binary to two's complement is a pure MSB flip.
    function automatic logic [AUDIO_DATA_W-1:0] to_signed_sample(
        input logic [AUDIO_DATA_W-1:0] s
    );
        return s ^ {1'b1, {(AUDIO_DATA_W-1){1'b0}}};
    endfunction

endpackage

// File: rtl/eoc_sync_edge.sv
// Three-flop synchroniser for an asynchronous ADC strobe
// with a single-cycle rising-edge pulse.
module eoc_sync_edge
    import audio_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    assign sync_d = {sync_q[1:0], async_i};

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/audio_frame_capture.sv
// Captures ADC samples into a ping-pong frame buffer and
// presents complete frames to the renderer via valid/ack.
module audio_frame_capture
    import audio_pkg::*;
#(
    parameter int DATA_W    = AUDIO_DATA_W,
    parameter int FRAME_LEN = AUDIO_FRAME_LEN,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] audio_in,
    input  logic              eoc,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_valid,
    input  logic              frame_ack,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_LEN - 1);

    logic              rise;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] wr_sample;
    logic              last_wr;
    logic              ack_eff;
    frame_hs_t         hs;

    logic [DATA_W-1:0] mem_q [2*FRAME_LEN];

    eoc_sync_edge u_eoc_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (eoc),
        .rise_o  (rise)
    );

    assign hs.valid   = valid_q;
    assign hs.ack     = frame_ack;
    assign hs.overrun = ovr_q;

    assign wr_sample = to_signed_sample(audio_in);
    assign last_wr   = rise && (wr_ptr_q == LAST_PTR);
    assign ack_eff   = hs.ack && hs.valid;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        if (rise) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (last_wr && (!hs.valid || hs.ack)) begin
            rd_bank_d = wr_bank_q;
            wr_bank_d = ~wr_bank_q;
            valid_d   = 1'b1;
            if (ack_eff) begin
                ovr_d = 1'b0;
            end
        end else if (last_wr) begin
            // Reader still busy: drop this frame, refill same bank.
            ovr_d = 1'b1;
        end else if (ack_eff) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            rd_data_q <= mem_q[{rd_bank_q, rd_addr}];
        end
    end

    always_ff @(posedge clk) begin
        if (reset && rise) begin
            mem_q[{wr_bank_q, wr_ptr_q}] <= wr_sample;
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_valid = hs.valid;
    assign overrun     = hs.overrun;

endmodule

// File: tb/tb_audio_frame_capture.sv
// Self-checking bench for audio_frame_capture (FRAME_LEN=8)
// using vector tables, directed sequences and a random model.
module tb_audio_frame_capture;

    localparam int DW = 8;
    localparam int FL = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] audio_in = '0;
    logic          eoc = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          frame_valid;
    logic          frame_ack = 1'b0;
    logic          overrun;

    audio_frame_capture #(
        .DATA_W    (DW),
        .FRAME_LEN (FL),
        .ADDR_W    (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .audio_in    (audio_in),
        .eoc         (eoc),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: frame under construction, presented frame, flags.
    logic [DW-1:0] m_cur[$];
    logic [DW-1:0] m_pres[FL];
    bit            m_valid;
    bit            m_ovr;
    logic          fv_before;

    typedef struct {
        logic [DW-1:0] adc;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t sine[FL];

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic logic [DW-1:0] conv(logic [DW-1:0] s);
        return 8'(int'(s) - 128);
    endfunction

    function automatic void m_write(logic [DW-1:0] s, bit ack_same);
        m_cur.push_back(conv(s));
        if (m_cur.size() == FL) begin
            if (!m_valid || ack_same) begin
                if (m_valid && ack_same) m_ovr = 1'b0;
                for (int i = 0; i < FL; i++) m_pres[i] = m_cur[i];
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            m_cur.delete();
        end
    endfunction

    task automatic send(logic [DW-1:0] s, int hi, int lo);
        @(negedge clk);
        audio_in = s;
        eoc = 1'b1;
        for (int i = 1; i <= hi; i++) begin
            @(negedge clk);
            if (i == 2) fv_before = frame_valid;
        end
        eoc = 1'b0;
        repeat (lo) @(negedge clk);
        m_write(s, 1'b0);
    endtask

    task automatic send_ack(logic [DW-1:0] s);
        @(negedge clk);
        audio_in = s;
        eoc = 1'b1;
        @(negedge clk);
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        eoc = 1'b0;
        repeat (3) @(negedge clk);
        m_write(s, 1'b1);
    endtask

    task automatic ack();
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr = 1'b0;
        end
        chk("ack_valid", 32'(frame_valid), 32'(m_valid));
        chk("ack_ovr", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic do_reset();
        @(negedge clk);
        eoc = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_cur.delete();
        m_valid = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic check_flags(string name);
        chk({name, "_valid"}, 32'(frame_valid), 32'(m_valid));
        chk({name, "_ovr"}, 32'(overrun), 32'(m_ovr));
    endtask

    task automatic check_frame(string name);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            rd_addr = AW'(i);
            @(negedge clk);
            chk($sformatf("%s[%0d]", name, i), 32'(rd_data),
                32'(m_pres[i]));
        end
    endtask

    task automatic send_rand_frame(int n);
        for (int i = 0; i < n; i++)
            send(8'($urandom), $urandom_range(3, 6), $urandom_range(2, 5));
    endtask

    initial begin
        sine[0] = '{8'h7F, 8'hFF};
        sine[1] = '{8'hD9, 8'h59};
        sine[2] = '{8'hFF, 8'h7F};
        sine[3] = '{8'hD9, 8'h59};
        sine[4] = '{8'h7F, 8'hFF};
        sine[5] = '{8'h25, 8'hA5};
        sine[6] = '{8'h00, 8'h80};
        sine[7] = '{8'h25, 8'hA5};
        m_valid = 1'b0;
        m_ovr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        check_flags("rst");

        // 20 kHz-ish eoc with constant 0x7F
        for (int i = 0; i < FL - 1; i++) send(8'h7F, 74, 74);
        check_flags("t1_pre");
        send(8'h7F, 74, 74);
        chk("t1_fv_before_write", 32'(fv_before), 32'h0);
        check_flags("t1_done");
        for (int i = 0; i < FL; i++)
            chk("t1_model_ff", 32'(m_pres[i]), 32'hFF);
        check_frame("t1_rd");

        // Sine ramp from vector table
        ack();
        for (int i = 0; i < FL; i++) send(sine[i].adc, 3, 3);
        check_flags("t2");
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            rd_addr = AW'(i);
            @(negedge clk);
            chk($sformatf("t2_sine[%0d]", i), 32'(rd_data),
                32'(sine[i].exp));
        end

        // Withhold ack for two frame periods
        send_rand_frame(FL);
        check_flags("t3_drop1");
        send_rand_frame(FL);
        check_flags("t3_drop2");
        chk("t3_ovr_set", 32'(overrun), 32'h1);
        check_frame("t3_untouched");
        ack();
        chk("t3_ack_clr", 32'(frame_valid | overrun), 32'h0);
        send_rand_frame(FL);
        check_flags("t3_fresh");
        check_frame("t3_fresh_rd");

        // Ack coincident with completion, after an overrun
        send_rand_frame(FL);
        chk("t4_ovr_pre", 32'(overrun), 32'h1);
        send_rand_frame(FL - 1);
        send_ack(8'($urandom));
        check_flags("t4");
        chk("t4_valid_kept", 32'(frame_valid), 32'h1);
        chk("t4_ovr_clr", 32'(overrun), 32'h0);
        check_frame("t4_rd");

        // Reset mid-frame
        send_rand_frame(FL);
        send_rand_frame(5);
        do_reset();
        chk("t5_valid", 32'(frame_valid), 32'h0);
        chk("t5_ovr", 32'(overrun), 32'h0);
        send_rand_frame(FL - 1);
        check_flags("t5_partial");
        send_rand_frame(1);
        check_flags("t5_full");
        check_frame("t5_rd");

        // Long eoc then a one-cycle glitch
        ack();
        send(8'h10, 100, 3);
        send(8'h20, 1, 3);
        send_rand_frame(FL - 3);
        check_flags("t6_partial");
        send_rand_frame(1);
        check_flags("t6_full");
        check_frame("t6_rd");

        // Random traffic against the model
        for (int k = 0; k < 200; k++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 7) begin
                send_rand_frame(1);
                check_flags("rnd");
            end else if (op < 9) begin
                ack();
            end else if (m_valid) begin
                check_frame("rnd_rd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/audio_frame_capture.md
Name: audio_frame_capture

Overview:
- Front-end stage between the external 8-bit ADC (parallel audio bits plus eoc strobe) and the display renderer.
- Synchronises eoc and captures one sample per conversion.
- Converts each sample from offset-binary to two's complement and stores it in a ping-pong frame buffer.
- Hands complete frames to the display stage with a valid/ack handshake; the renderer reads them by address while the next frame fills.

Parameters:
- DATA_W, 8, sample width in bits.
- FRAME_LEN, 64, samples per frame; power of two, at least 4.
- ADDR_W, $clog2(FRAME_LEN), read-address width.

Ports:
- clk  in  1  system clock (~2.94 MHz).
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
- audio_in  in  DATA_W  ADC parallel output, offset-binary (128 = zero); stable while eoc is high.
- eoc  in  1  ADC end-of-conversion, asynchronous to clk; one rising edge per sample.
- rd_addr  in  ADDR_W  read address into the frame currently presented.
- rd_data  out  DATA_W  two's-complement sample at rd_addr.
- frame_valid  out  1  a complete frame is available for reading.
- frame_ack  in  1  one-cycle pulse from the renderer: frame consumed, release bank.
- overrun  out  1  sticky flag: at least one frame was dropped since the last ack.

Behaviour:
- Reset (reset=0 at a clk edge):
  - Synchroniser flops, wr_ptr, wr_bank and rd_bank go to 0.
  - frame_valid, overrun and rd_data go to 0.
  - Memory contents are not cleared.
  - A reset mid-frame discards the partial frame and any presented frame.
- eoc synchronisation:
  - Chain eoc_s1 -> eoc_s2 -> eoc_s3.
  - rise = eoc_s2 & ~eoc_s3.
  - The write happens in the cycle where rise=1, i.e. the 3rd clk edge after eoc goes high.
  - audio_in is sampled in that cycle.
- Conversion: stored value = audio_in with the MSB inverted (audio_in ^ 8'h80). Examples: 0x7F -> 0x FF (-1), 0x80 -> 0x00, 0xFF -> 0x7F, 0x00 -> 0x80.
- Write: mem[wr_bank][wr_ptr] <= converted value; wr_ptr increments, wrapping FRAME_LEN-1 -> 0.
- Frame completion, on the write at wr_ptr = FRAME_LEN-1:
  - Reader bank free (frame_valid=0, or frame_ack=1 this same cycle):
    - rd_bank <= wr_bank; wr_bank toggles.
    - frame_valid = 1 from the next cycle.
    - If frame_ack was also high this cycle, overrun clears and frame_valid stays 1 with the new bank.
  - Reader bank busy (frame_valid=1 and no ack):
    - The frame is dropped; wr_bank is unchanged and wr_ptr wraps to 0, so the next frame overwrites the same bank.
    - overrun <= 1.
    - The presented frame is untouched.
- frame_ack:
  - Ignored when frame_valid=0.
  - Otherwise frame_valid falls on the next edge and overrun clears, unless a completion in the same cycle re-asserts them per the rules above.
- Read path:
  - rd_data <= mem[rd_bank][rd_addr], registered, one-cycle latency.
  - Valid only while frame_valid=1; otherwise rd_data holds stale contents. The contents are don't-care, but rd_data must not be X after the first frame.
  - Reads never observe the bank being written.
- eoc glitches shorter than 2 clk periods may be missed; that is acceptable. eoc held high produces exactly one write.
- Width rules: wr_ptr is ADDR_W bits wide and wraps naturally; there is no arithmetic beyond the MSB inversion.

Decomposition:
- Shared package (audio_pkg):
  - DATA_W and FRAME_LEN constants.
  - Function to_signed_sample (MSB inversion).
  - Frame handshake typedef (valid, ack, overrun).
- Sub-module eoc_sync_edge: 3-flop synchroniser plus rising-edge pulse, with clk/reset. It is reused for any other async strobe from the ADC board.
- The ping-pong memory is inferred inline as a 2*FRAME_LEN x DATA_W array addressed by {bank, ptr}.

Test Plan:
- Reset then constant audio_in=0x7F with eoc toggling at 20 kHz (25 µs high / 25 µs low), FRAME_LEN=8 -> frame_valid rises 1 cycle after the 8th write, 3 cycles after the 8th eoc rise; rd_addr 0..7 returns 0xFF each with 1-cycle latency.
- Sine ramp of 8 samples (0x7F,0xD9,0xFF,0xD9,0x7F,0x25,0x00,0x25) -> rd_data reads 0xFF,0x59,0x7F,0x59,0xFF,0xA5,0x80,0xA5.
- Withhold frame_ack for 2 frame periods -> overrun=1 after the 2nd completion; presented data is unchanged; ack -> frame_valid=0 and overrun=0 next cycle; the following frame is fresh.
- frame_ack asserted in the same cycle as a frame completion -> frame_valid stays 1, rd_bank switches to the new frame, overrun=0.
- Assert reset=0 for 1 cycle mid-frame (after 5 samples) -> frame_valid=0, overrun=0; the next frame needs a full FRAME_LEN eoc edges before frame_valid rises.
- Hold eoc high for 100 cycles, then a 1-cycle eoc glitch -> exactly one write from the long pulse; wr_ptr advances by at most 1 for the glitch.
